// File: rtl/multi_edge_detector.sv
// multi_edge_detector
//   Multi-channel edge detector for asynchronous level inputs.
//   Each channel runs through a synchroniser and an optional debounce filter.
//   It then drives a registered one-cycle edge pulse and a sticky event flag.
//   The detect mode is shared by all channels.
//   Build option: define MULTI_EDGE_DETECTOR_DEBOUNCE_EN to build the
//   debounce counters. Without it, o_level is the synchronised input delayed
//   by one register.
module multi_edge_detector #(
  parameter int WIDTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic             i_clock,
  input  logic             i_resetL,
  input  logic [WIDTH-1:0] i_level,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_clear,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_pulse,
  output logic [WIDTH-1:0] o_sticky,
  output logic             o_any
);

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  // Reject nonsensical configurations at elaboration time.
  if (WIDTH < 1 || SYNC_STAGES < 2 || DEBOUNCE_CNT < 1) begin : g_bad_cfg
    $error("multi_edge_detector: WIDTH>=1, SYNC_STAGES>=2, DEBOUNCE_CNT>=1 required");
  end

  mode_e mode;
  assign mode = mode_e'(i_mode);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_s;
  logic [WIDTH-1:0]                  level_q, level_d;
  logic [WIDTH-1:0]                  pulse_q, pulse_d;
  logic [WIDTH-1:0]                  sticky_q, sticky_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the raw pin, the last stage is s[i].
  // NOTE: the synchroniser is reset too, so a channel that is high at reset
  // release is seen as a fresh rising edge instead of an unknown value.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value
      // of its predecessor, which is what makes this a shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_level};
    end
  end

`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  // Debounce: the filtered level only follows s[i] after DEBOUNCE_CNT
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit (no latches).
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE_CNT - 1)) begin
        level_d[i] = sync_s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Debounce counter state; a partially counted debounce dies with reset.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without debounce the filtered level is simply s[i] registered once.
  assign level_d = sync_s;
`endif

  // Edge detection on the filtered level and sticky flag update.
  always_comb begin
    pulse_d = '0;
    unique case (mode)
      MODE_RISE: pulse_d = level_d & ~level_q;
      MODE_FALL: pulse_d = ~level_d & level_q;
      MODE_BOTH: pulse_d = level_d ^ level_q;
      MODE_OFF:  pulse_d = '0;
      default:   pulse_d = '0;
    endcase
    // Set has priority over clear on the same edge.
    sticky_d = (sticky_q & ~i_clear) | pulse_d;
  end

  // Output registers: filtered level, edge pulse, sticky flags.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      level_q  <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
    end else begin
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
    end
  end

  assign o_level  = level_q;
  assign o_pulse  = pulse_q;
  assign o_sticky = sticky_q;
  assign o_any    = |sticky_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// tb_multi_edge_detector
//   Directed self-checking bench for multi_edge_detector (WIDTH=4,
//   SYNC_STAGES=2, DEBOUNCE_CNT=8). Expected latencies follow the
//   MULTI_EDGE_DETECTOR_DEBOUNCE_EN build option.
module tb_multi_edge_detector;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DC = 8;
`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
  localparam int LAT = SS + DC;
  localparam int MID = SS + 5;   // counter reaches 5
`else
  localparam int LAT = SS + 1;
  localparam int MID = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_l;
  logic [W-1:0] level_in;
  logic [1:0]   mode;
  logic [W-1:0] clear;
  logic [W-1:0] level_out, pulse, sticky;
  logic         any;
  logic [W-1:0] seen;

  int checks = 0;
  int errors = 0;

  multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CNT(DC)) dut (
    .i_clock  (clk),
    .i_resetL (rst_l),
    .i_level  (level_in),
    .i_mode   (i_mode_sig()),
    .i_clear  (clear),
    .o_level  (level_out),
    .o_pulse  (pulse),
    .o_sticky (sticky),
    .o_any    (any)
  );

  function automatic logic [1:0] i_mode_sig();
    return mode;
  endfunction

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then step 1 time unit away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, collecting every pulse seen.
  task automatic run_collect(input int n, output logic [W-1:0] acc);
    acc = '0;
    repeat (n) begin
      tick();
      acc |= pulse;
    end
  endtask

  initial begin
    rst_l    = 1'b0;
    level_in = 4'b0011;
    mode     = 2'b00;
    clear    = '0;
    tick();
    tick();
    check("reset_level",  level_out, 4'b0000);
    check("reset_pulse",  pulse,     4'b0000);
    check("reset_sticky", sticky,    4'b0000);
    check("reset_any",    any,       1'b0);

    // Reset release with inputs high: one rising edge on ch0/ch1.
    rst_l = 1'b1;
    repeat (LAT - 1) tick();
    check("rst_rise_early_pulse", pulse, 4'b0000);
    check("rst_rise_early_level", level_out, 4'b0000);
    tick();
    check("rst_rise_pulse",  pulse,     4'b0011);
    check("rst_rise_sticky", sticky,    4'b0011);
    check("rst_rise_any",    any,       1'b1);
    check("rst_rise_level",  level_out, 4'b0011);
    tick();
    check("rst_rise_width", pulse,  4'b0000);
    check("rst_rise_hold",  sticky, 4'b0011);

    clear = 4'b1111;
    tick();
    clear = '0;
    check("clear_all_sticky", sticky, 4'b0000);
    check("clear_all_any",    any,    1'b0);

    // Rising mode ignores falls.
    level_in = 4'b0000;
    run_collect(LAT + 2, seen);
    check("rise_mode_no_fall_pulse", seen,      4'b0000);
    check("fall_level_tracked",      level_out, 4'b0000);

    // Both-edges mode on ch0.
    mode = 2'b10;
`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
    level_in = 4'b0001;
    repeat (DC - 1) tick();
    level_in = 4'b0000;
    run_collect(LAT + 4, seen);
    check("glitch_no_pulse", seen,      4'b0000);
    check("glitch_level",    level_out, 4'b0000);
    check("glitch_sticky",   sticky,    4'b0000);
`endif
    level_in = 4'b0001;
    repeat (LAT - 1) tick();
    check("both_rise_early", pulse, 4'b0000);
    tick();
    check("both_rise_pulse",  pulse,     4'b0001);
    check("both_rise_level",  level_out, 4'b0001);
    check("both_rise_sticky", sticky,    4'b0001);
    tick();
    check("both_rise_width", pulse, 4'b0000);
    level_in = 4'b0000;
    repeat (LAT) tick();
    check("both_fall_pulse", pulse,     4'b0001);
    check("both_fall_level", level_out, 4'b0000);

    clear = 4'b1111;
    tick();
    clear = '0;
    check("clear2_sticky", sticky, 4'b0000);

    // Falling mode on ch2.
    mode     = 2'b01;
    level_in = 4'b0100;
    repeat (LAT) tick();
    check("fall_mode_rise_pulse",  pulse,     4'b0000);
    check("fall_mode_rise_level",  level_out, 4'b0100);
    check("fall_mode_rise_sticky", sticky,    4'b0000);
    level_in = 4'b0000;
    repeat (LAT) tick();
    check("fall_mode_fall_pulse",  pulse,     4'b0100);
    check("fall_mode_fall_level",  level_out, 4'b0000);
    check("fall_mode_fall_sticky", sticky,    4'b0100);

    // Disabled mode: levels track, nothing pulses, sticky unchanged.
    mode     = 2'b11;
    level_in = 4'b1111;
    run_collect(LAT + 2, seen);
    check("off_rise_no_pulse", seen,      4'b0000);
    check("off_rise_level",    level_out, 4'b1111);
    check("off_rise_sticky",   sticky,    4'b0100);
    level_in = 4'b0000;
    run_collect(LAT + 2, seen);
    check("off_fall_no_pulse", seen,      4'b0000);
    check("off_fall_level",    level_out, 4'b0000);

    // Set/clear collision on ch1: set wins, then clear alone clears.
    mode     = 2'b00;
    level_in = 4'b0010;
    repeat (LAT - 1) tick();
    check("coll_early_pulse", pulse, 4'b0000);
    clear = 4'b0010;
    tick();
    check("coll_pulse",  pulse,  4'b0010);
    check("coll_sticky", sticky, 4'b0110);
    clear = 4'b0110;
    tick();
    clear = '0;
    check("coll_clear_sticky", sticky, 4'b0000);
    check("coll_clear_any",    any,    1'b0);

    // Reset in the middle of a ch3 debounce.
    level_in = 4'b1010;
    repeat (MID) tick();
    rst_l = 1'b0;
    #1;
    check("midrst_level",  level_out, 4'b0000);
    check("midrst_pulse",  pulse,     4'b0000);
    check("midrst_sticky", sticky,    4'b0000);
    check("midrst_any",    any,       1'b0);
    tick();
    rst_l = 1'b1;
    repeat (LAT - 1) tick();
    check("midrst_early_pulse", pulse, 4'b0000);
    tick();
    check("midrst_pulse_after", pulse,     4'b1010);
    check("midrst_level_after", level_out, 4'b1010);
    check("midrst_any_after",   any,       1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
